// File: rtl/bambu_ext_mem_pkg.sv
// Shared definitions for the external memory responder.
//   MEM_DELAY_READ_DEF / MEM_DELAY_WRITE_DEF : default read/write latencies
//   size_to_mask()                          : access size in bits -> byte mask
package bambu_ext_mem_pkg;

  localparam int unsigned MEM_DELAY_READ_DEF  = 2;
  localparam int unsigned MEM_DELAY_WRITE_DEF = 1;

  // (1<<size)-1 evaluated 9 bits wide, saturated to a full byte for size >= 8.
  function automatic logic [7:0] size_to_mask(input logic [3:0] size);
    if (size >= 4'd8) begin
      return 8'hFF;
    end
    return 8'((9'd1 << size) - 9'd1);
  endfunction

endpackage

// File: rtl/ext_mem_channel.sv
// One channel of the external memory responder.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   oe, we, addr         : channel request from the master bus
//   wdata, size          : channel write byte and access size in bits
//   rd_byte              : array byte at idx, read combinationally by the top
//   sout_rdata, sout_rdy : slave-side response OR-merged into the outputs
//   idx                  : array index (valid while the address is in range)
//   wr_byte, wr_mask     : byte and mask for the array update
//   wr_en                : commit a write on this edge
//   rdata, rdy           : merged read data and ready for this channel
module ext_mem_channel
  import bambu_ext_mem_pkg::*;
#(
  parameter int unsigned MEMSIZE     = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned AW          = 7,
  parameter int unsigned IW          = 5,
  parameter int unsigned READ_DELAY  = MEM_DELAY_READ_DEF,
  parameter int unsigned WRITE_DELAY = MEM_DELAY_WRITE_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          oe,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  input  logic [3:0]    size,
  input  logic [7:0]    rd_byte,
  input  logic [7:0]    sout_rdata,
  input  logic          sout_rdy,
  output logic [IW-1:0] idx,
  output logic [7:0]    wr_byte,
  output logic [7:0]    wr_mask,
  output logic          wr_en,
  output logic [7:0]    rdata,
  output logic          rdy
);

  localparam logic [3:0] RD_LAST = 4'(READ_DELAY - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_DELAY - 1);

  logic [32:0] diff;
  logic        in_range;
  logic [2:0]  cnt_reg;
  logic [2:0]  cnt_next;
  logic [3:0]  cnt_ext;
  logic [7:0]  rd_in;
  logic [7:0]  tail;

  // 33-bit subtraction: bit 32 flags addresses below BASE_ADDR without
  // needing a separate lower-bound compare.
  assign diff     = {1'b0, 32'(addr)} - 33'(BASE_ADDR);
  assign in_range = ~diff[32] & (diff[31:0] < MEMSIZE);
  assign idx      = diff[IW-1:0];
  assign cnt_ext  = {1'b0, cnt_reg};

  // "cnt < LAST" is written as "cnt + 1 <= LAST" in 4 bits so the compare
  // stays meaningful when LAST is zero.
  always_comb begin
    cnt_next = 3'd0;
    if (oe && in_range) begin
      if ((cnt_ext + 4'd1) <= RD_LAST) cnt_next = cnt_reg + 3'd1;
    end else if (we && in_range) begin
      if ((cnt_ext + 4'd1) <= WR_LAST) cnt_next = cnt_reg + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_reg <= 3'd0;
    else        cnt_reg <= cnt_next;
  end

  // Internal ready is masked while reset is low so only the slave side shows.
  assign rdy = sout_rdy |
               (reset & in_range & ((cnt_ext == RD_LAST) | (we & (cnt_ext == WR_LAST))));

  assign rd_in = in_range ? rd_byte : 8'h00;

  generate
    if (READ_DELAY == 1) begin : g_bypass
      assign tail = reset ? rd_in : 8'h00;
    end else begin : g_pipe
      logic [7:0] pipe_reg [READ_DELAY-1];
      for (genvar gi = 0; gi < int'(READ_DELAY) - 1; gi++) begin : g_stage
        always_ff @(posedge clock or negedge reset) begin
          if (!reset)       pipe_reg[gi] <= 8'h00;
          else if (gi == 0) pipe_reg[gi] <= rd_in;
          else              pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
      assign tail = pipe_reg[READ_DELAY-2];
    end
  endgenerate

  assign rdata   = tail | sout_rdata;
  assign wr_byte = wdata;
  assign wr_mask = size_to_mask(size);
  // A simultaneous read wins: the request is treated as a read only.
  assign wr_en   = reset & we & ~oe & in_range;

endmodule

// File: rtl/bambu_ext_mem_responder.sv
// Off-chip memory responder for the Bambu `main` master memory port.
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   Mout_*                : two-channel request bus from the accelerator
//   Sout_Rdata_ram/DataRdy: slave response from `main`, OR-merged into outputs
//   init_we/addr/data     : byte-wide preload port for the array
//   M_Rdata_ram, M_DataRdy: read data and per-channel ready back to `main`
//   err_both_en           : sticky, oe and we seen together on one channel
module bambu_ext_mem_responder
  import bambu_ext_mem_pkg::*;
#(
  parameter int unsigned MEMSIZE     = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned AW          = 7,
  parameter int unsigned READ_DELAY  = MEM_DELAY_READ_DEF,
  parameter int unsigned WRITE_DELAY = MEM_DELAY_WRITE_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      Mout_oe_ram,
  input  logic [1:0]      Mout_we_ram,
  input  logic [2*AW-1:0] Mout_addr_ram,
  input  logic [15:0]     Mout_Wdata_ram,
  input  logic [7:0]      Mout_data_ram_size,
  input  logic [15:0]     Sout_Rdata_ram,
  input  logic [1:0]      Sout_DataRdy,
  input  logic            init_we,
  input  logic [AW-1:0]   init_addr,
  input  logic [7:0]      init_data,
  output logic [15:0]     M_Rdata_ram,
  output logic [1:0]      M_DataRdy,
  output logic            err_both_en
);

  localparam int unsigned IW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  // Not reset: contents come only from the preload port or master writes.
  logic [7:0]    mem [MEMSIZE];

  logic [IW-1:0] ch_idx     [2];
  logic [7:0]    ch_wr_byte [2];
  logic [7:0]    ch_wr_mask [2];
  logic [7:0]    ch_rd_byte [2];
  logic [1:0]    ch_wr_en;
  logic [31:0]   init_addr_ext;
  logic          init_ok;
  logic [IW-1:0] init_idx;
  logic          err_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      assign ch_rd_byte[gi] = mem[ch_idx[gi]];

      ext_mem_channel #(
        .MEMSIZE     (MEMSIZE),
        .BASE_ADDR   (BASE_ADDR),
        .AW          (AW),
        .IW          (IW),
        .READ_DELAY  (READ_DELAY),
        .WRITE_DELAY (WRITE_DELAY)
      ) u_ch (
        .clock      (clock),
        .reset      (reset),
        .oe         (Mout_oe_ram[gi]),
        .we         (Mout_we_ram[gi]),
        .addr       (Mout_addr_ram[gi*AW +: AW]),
        .wdata      (Mout_Wdata_ram[gi*8 +: 8]),
        .size       (Mout_data_ram_size[gi*4 +: 4]),
        .rd_byte    (ch_rd_byte[gi]),
        .sout_rdata (Sout_Rdata_ram[gi*8 +: 8]),
        .sout_rdy   (Sout_DataRdy[gi]),
        .idx        (ch_idx[gi]),
        .wr_byte    (ch_wr_byte[gi]),
        .wr_mask    (ch_wr_mask[gi]),
        .wr_en      (ch_wr_en[gi]),
        .rdata      (M_Rdata_ram[gi*8 +: 8]),
        .rdy        (M_DataRdy[gi])
      );
    end
  endgenerate

  assign init_addr_ext = 32'(init_addr);
  assign init_ok       = init_addr_ext < MEMSIZE;
  assign init_idx      = init_addr_ext[IW-1:0];

  // Later assignments win on a shared index: preload > channel 1 > channel 0.
  // Each merge reads the pre-edge byte, so the winner replaces it outright.
  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (ch_wr_en[c]) begin
        mem[ch_idx[c]] <= (ch_wr_byte[c] & ch_wr_mask[c]) |
                          (mem[ch_idx[c]] & ~ch_wr_mask[c]);
      end
    end
    if (init_we && init_ok) mem[init_idx] <= init_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          err_reg <= 1'b0;
    else if (|(Mout_oe_ram & Mout_we_ram)) err_reg <= 1'b1;
  end

  assign err_both_en = err_reg;

endmodule

// File: tb/tb_bambu_ext_mem_responder.sv
module tb_bambu_ext_mem_responder;

  localparam int AW = 7;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      Mout_oe_ram;
  logic [1:0]      Mout_we_ram;
  logic [2*AW-1:0] Mout_addr_ram;
  logic [15:0]     Mout_Wdata_ram;
  logic [7:0]      Mout_data_ram_size;
  logic [15:0]     Sout_Rdata_ram;
  logic [1:0]      Sout_DataRdy;
  logic            init_we;
  logic [AW-1:0]   init_addr;
  logic [7:0]      init_data;
  logic [15:0]     M_Rdata_ram;
  logic [1:0]      M_DataRdy;
  logic            err_both_en;

  int n_cmp = 0;
  int n_err = 0;

  bambu_ext_mem_responder #(
    .MEMSIZE(32), .BASE_ADDR(0), .AW(AW), .READ_DELAY(2), .WRITE_DELAY(1)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size),
    .Sout_Rdata_ram     (Sout_Rdata_ram),
    .Sout_DataRdy       (Sout_DataRdy),
    .init_we            (init_we),
    .init_addr          (init_addr),
    .init_data          (init_data),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .err_both_en        (err_both_en)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    Mout_oe_ram        = 2'b00;
    Mout_we_ram        = 2'b00;
    Mout_addr_ram      = '0;
    Mout_Wdata_ram     = 16'h0000;
    Mout_data_ram_size = 8'h00;
    Sout_Rdata_ram     = 16'h0000;
    Sout_DataRdy       = 2'b00;
    init_we            = 1'b0;
    init_addr          = '0;
    init_data          = 8'h00;
  endtask

  task automatic preload(input int idx, input logic [7:0] data);
    init_we   = 1'b1;
    init_addr = 7'(idx);
    init_data = data;
    tick();
    init_we   = 1'b0;
  endtask

  // Read with READ_DELAY=2: no ready in t, ready and data in t+1.
  task automatic do_read(input int ch, input int addr, input logic [7:0] exp, input string tag);
    Mout_oe_ram[ch]              = 1'b1;
    Mout_addr_ram[ch*AW +: AW]   = 7'(addr);
    #1;
    check({tag, "_rdy_t0"}, 32'(M_DataRdy[ch]), 32'd0);
    tick();
    check({tag, "_rdy_t1"}, 32'(M_DataRdy[ch]), 32'd1);
    check({tag, "_data"}, 32'(M_Rdata_ram[ch*8 +: 8]), 32'(exp));
    Mout_oe_ram[ch] = 1'b0;
    tick();
  endtask

  // Write with WRITE_DELAY=1: ready in the same cycle, committed at the edge.
  task automatic do_write(input int ch, input int addr, input logic [7:0] data,
                          input logic [3:0] size, input string tag);
    Mout_we_ram[ch]                 = 1'b1;
    Mout_addr_ram[ch*AW +: AW]      = 7'(addr);
    Mout_Wdata_ram[ch*8 +: 8]       = data;
    Mout_data_ram_size[ch*4 +: 4]   = size;
    #1;
    check({tag, "_wrdy"}, 32'(M_DataRdy[ch]), 32'd1);
    tick();
    Mout_we_ram[ch] = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b0;

    // During reset the outputs are the slave-side terms alone.
    Sout_DataRdy   = 2'b10;
    Sout_Rdata_ram = 16'hBEEF;
    Mout_oe_ram    = 2'b01;
    tick();
    tick();
    check("rst_rdy_pass", 32'(M_DataRdy), 32'h2);
    check("rst_data_pass", 32'(M_Rdata_ram), 32'hBEEF);
    check("rst_err", 32'(err_both_en), 32'd0);
    idle();
    #1;
    check("rst_rdy_zero", 32'(M_DataRdy), 32'd0);
    check("rst_data_zero", 32'(M_Rdata_ram), 32'd0);

    reset = 1'b1;
    tick();
    preload(0, 8'h11);
    preload(1, 8'h22);
    preload(2, 8'h33);
    preload(3, 8'h44);
    preload(4, 8'hAB);
    preload(5, 8'hFF);
    preload(6, 8'h00);
    preload(7, 8'h00);
    preload(31, 8'h9C);

    // Both channels read together; held oe restarts in t+2.
    Mout_oe_ram   = 2'b11;
    Mout_addr_ram = {7'd0, 7'd2};
    #1;
    check("rdA_rdy_t0", 32'(M_DataRdy), 32'd0);
    tick();
    check("rdA_rdy_t1", 32'(M_DataRdy), 32'h3);
    check("rdA_data", 32'(M_Rdata_ram), 32'h1133);
    tick();
    check("rdA_rdy_t2", 32'(M_DataRdy), 32'd0);
    idle();
    tick();

    // Nibble write over 0xFF, size 0 leaves the byte, size 12 saturates.
    do_write(1, 5, 8'hA5, 4'd4, "wr_sz4");
    do_read(1, 5, 8'hF5, "rd_sz4");
    do_write(0, 1, 8'h00, 4'd0, "wr_sz0");
    do_read(0, 1, 8'h22, "rd_sz0");
    do_write(0, 6, 8'h3C, 4'd12, "wr_sz12");
    do_read(1, 6, 8'h3C, "rd_sz12");

    // Same-index writes from both channels: channel 1 wins.
    Mout_we_ram        = 2'b11;
    Mout_addr_ram      = {7'd7, 7'd7};
    Mout_Wdata_ram     = 16'h0201;
    Mout_data_ram_size = 8'h88;
    #1;
    check("wr_both_rdy", 32'(M_DataRdy), 32'h3);
    tick();
    idle();
    do_read(0, 7, 8'h02, "rd_prio");

    // Range edges: 31 is the last byte, 32 gets no response.
    do_read(0, 31, 8'h9C, "rd_last");
    Mout_oe_ram[1]        = 1'b1;
    Mout_addr_ram[13:7]   = 7'd32;
    tick();
    check("oor32_rdy", 32'(M_DataRdy[1]), 32'd0);
    check("oor32_data", 32'(M_Rdata_ram[15:8]), 32'd0);
    idle();
    tick();

    // Out-of-range read held for four cycles, then slave-side merge.
    Mout_oe_ram[0]      = 1'b1;
    Mout_addr_ram[6:0]  = 7'd40;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("oor40_rdy_%0d", i), 32'(M_DataRdy[0]), 32'd0);
      check($sformatf("oor40_data_%0d", i), 32'(M_Rdata_ram[7:0]), 32'd0);
    end
    Sout_DataRdy   = 2'b01;
    Sout_Rdata_ram = 16'h005A;
    #1;
    check("sout_rdy", 32'(M_DataRdy[0]), 32'd1);
    check("sout_data", 32'(M_Rdata_ram[7:0]), 32'h5A);
    idle();
    tick();

    // oe and we together: sticky error, no write committed.
    Mout_oe_ram        = 2'b01;
    Mout_we_ram        = 2'b01;
    Mout_addr_ram[6:0] = 7'd4;
    Mout_Wdata_ram     = 16'h0077;
    Mout_data_ram_size = 8'h08;
    #1;
    check("err_before", 32'(err_both_en), 32'd0);
    tick();
    idle();
    check("err_set", 32'(err_both_en), 32'd1);
    tick();
    tick();
    check("err_held", 32'(err_both_en), 32'd1);
    do_read(0, 4, 8'hAB, "rd_nowr");

    // Read and write of the same index in one cycle: read sees the old byte.
    Mout_oe_ram        = 2'b01;
    Mout_we_ram        = 2'b10;
    Mout_addr_ram      = {7'd2, 7'd2};
    Mout_Wdata_ram     = 16'h9900;
    Mout_data_ram_size = 8'h80;
    #1;
    check("raw_rdy_t0", 32'(M_DataRdy), 32'h2);
    tick();
    Mout_we_ram = 2'b00;
    check("raw_rdy_t1", 32'(M_DataRdy[0]), 32'd1);
    check("raw_old", 32'(M_Rdata_ram[7:0]), 32'h33);
    idle();
    tick();
    do_read(1, 2, 8'h99, "raw_new");

    // Reset in the first cycle of a read, plus a write during reset.
    Mout_oe_ram        = 2'b01;
    Mout_addr_ram[6:0] = 7'd2;
    #1;
    reset = 1'b0;
    #1;
    check("mid_err_clr", 32'(err_both_en), 32'd0);
    tick();
    check("mid_rdy", 32'(M_DataRdy), 32'd0);
    check("mid_data", 32'(M_Rdata_ram), 32'd0);
    idle();
    Mout_we_ram        = 2'b10;
    Mout_addr_ram      = {7'd3, 7'd0};
    Mout_Wdata_ram     = 16'hEE00;
    Mout_data_ram_size = 8'h80;
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    do_read(0, 2, 8'h99, "post_rst_rd");
    do_read(1, 3, 8'h44, "rst_wr_lost");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
